bram_port_master: RTL and testbench

- Initiator-side adapter that drives the A port of the team's 2048x32 single-port block RAM (OUTREG mode, read latency 2).
- Accepts read and write requests on a valid/ready channel and turns them into BRAM port strobes.
- Returns read data on a valid/ready response channel.
- Uses credit-based flow control, so read data coming out of the BRAM pipeline is never dropped under back-pressure.

---
 rtl/bram_port_pkg.sv | 15 +
 rtl/bram_rsp_fifo.sv | 48 ++++
 rtl/bram_port_master.sv | 87 ++++++++
 tb/tb_bram_port_master.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_port_pkg.sv
// Shared types and constants for the BRAM port master.
// Request bundle and BRAM geometry.
package bram_port_pkg;

  localparam int ADDR_W     = 11;
  localparam int DATA_W     = 32;
  localparam int RD_LATENCY = 2;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/bram_rsp_fifo.sv
// First-word-fall-through response FIFO.
// Async reset clears pointers and count; storage is not reset.
module bram_rsp_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;

  assign valid = (count != '0);
  assign dout  = mem[rp];

  // Pointers wrap naturally; push and pop together leave count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Data storage, written at the tail.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

endmodule

// File: rtl/bram_port_master.sv
// Initiator adapter driving BRAM port A with credit-based
// read flow control so pipelined read data is never dropped.
module bram_port_master #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 32,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_di,
  output logic              mem_oce,
  output logic              mem_rst,
  input  logic [DATA_W-1:0] mem_do,
  output logic              idle
);

  import bram_port_pkg::req_t;

  localparam int CW = $clog2(RSP_DEPTH) + 1;

  req_t          req;
  logic          s1;
  logic          s2;
  logic          fire;
  logic          rd_fire;
  logic          pop;
  logic [CW-1:0] count;
  logic [CW:0]   used;

  assign req = '{we: req_we, addr: req_addr, wdata: req_wdata};

  // Every buffered or in-flight read holds one FIFO slot.
  assign used = {1'b0, count}
              + {{CW{1'b0}}, s1}
              + {{CW{1'b0}}, s2};

  assign req_ready = !rsta && (used < (CW+1)'(RSP_DEPTH));
  assign fire      = req_valid & req_ready;
  assign rd_fire   = fire & ~req.we;

  assign mem_ce   = fire;
  assign mem_we   = fire & req.we;
  assign mem_addr = req.addr;
  assign mem_di   = req.wdata;
  assign mem_oce  = s1;
  assign mem_rst  = 1'b0;

  assign pop  = rsp_valid & rsp_ready;
  assign idle = !s1 && !s2 && (count == '0);

  // Track reads through the two-stage BRAM pipeline.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= rd_fire;
      s2 <= s1;
    end
  end

  bram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clka),
    .rst   (rsta),
    .push  (s2),
    .din   (mem_do),
    .pop   (pop),
    .valid (rsp_valid),
    .dout  (rsp_rdata),
    .count (count)
  );

endmodule

// File: tb/tb_bram_port_master.sv
// Scoreboard bench for bram_port_master with a
// behavioural BRAM and a reference memory model.
module tb_bram_port_master;

  logic        clka;
  logic        rsta;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [10:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [10:0] mem_addr;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_di;
  logic        mem_oce;
  logic        mem_rst;
  logic [31:0] mem_do;
  logic        idle;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int nfire    = 0;
  int vcnt     = 0;
  int first_v  = -1;
  int last_v   = -1;

  logic [31:0] ref_mem [2048];
  logic [31:0] expq [$];

  logic [31:0] bram [2048];
  logic [31:0] lat;
  logic [31:0] doreg;

  bram_port_master dut (
    .clka      (clka),
    .rsta      (rsta),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_ce    (mem_ce),
    .mem_we    (mem_we),
    .mem_di    (mem_di),
    .mem_oce   (mem_oce),
    .mem_rst   (mem_rst),
    .mem_do    (mem_do),
    .idle      (idle)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  always @(posedge clka) cyc++;

  // Behavioural 2048x32 BRAM, output register enabled by oce.
  always @(posedge clka) begin
    if (mem_ce) begin
      if (mem_we) bram[mem_addr] <= mem_di;
      else        lat <= bram[mem_addr];
    end
    if (mem_oce) doreg <= lat;
  end
  assign mem_do = doreg;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h",
               name, act, exp);
    end
  endtask

  // Reference model on request fire, scoreboard on response.
  always @(negedge clka) begin
    if (!rsta) begin
      if (req_valid && req_ready) begin
        nfire++;
        if (req_we) ref_mem[req_addr] = req_wdata;
        else        expq.push_back(ref_mem[req_addr]);
      end
      if (rsp_valid) begin
        vcnt++;
        last_v = cyc;
        if (first_v < 0) first_v = cyc;
      end
      if (rsp_valid && rsp_ready) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected actual=%h expected=none",
                   rsp_rdata);
        end else begin
          chk("rsp_data", rsp_rdata, expq.pop_front());
        end
      end
      if (dut.u_fifo.push && dut.u_fifo.count == 4) begin
        failures++;
        $display("FAIL fifo_overflow actual=push_at_full required=no_push");
      end
    end
  end

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic issue(bit we, logic [10:0] a, logic [31:0] d);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    @(negedge clka);
    while (!req_ready && n < 50) begin
      @(negedge clka);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout actual=no_ready required=ready");
    end
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [10:0] a;
    rsta      = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    #3;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_idle", idle, 1);
    repeat (2) @(posedge clka);
    #1 rsta = 1'b0;
    @(negedge clka);
    chk("ready_after_reset", req_ready, 1);
    tick();

    // Write then read back with latency measurement.
    issue(1'b1, 11'h005, 32'hDEADBEEF);
    issue(1'b0, 11'h005, 32'h0);
    n = 0;
    do begin
      @(negedge clka);
      n++;
    end while (!rsp_valid && n < 20);
    chk("rd_latency", n, 3);
    tick();
    tick();
    chk("idle_after_read", idle, 1);

    // Streaming reads of preloaded addresses.
    for (int i = 0; i < 16; i++) issue(1'b1, 11'(i), 32'(i * 3));
    first_v = -1;
    vcnt    = 0;
    n       = 0;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 11'(i);
      @(negedge clka);
      if (!req_ready) n++;
      tick();
    end
    req_valid = 1'b0;
    repeat (6) tick();
    chk("stream_ready_low", n, 0);
    chk("stream_rsp_count", vcnt, 16);
    chk("stream_no_gaps", last_v - first_v, 15);

    // Back-pressure: credits limit acceptance to four reads.
    rsp_ready = 1'b0;
    n = nfire;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 11'h003;
    repeat (10) tick();
    req_valid = 1'b0;
    tick();
    chk("bp_accepted", nfire - n, 4);
    @(negedge clka);
    chk("bp_ready_low", req_ready, 0);
    tick();
    rsp_ready = 1'b1;
    @(negedge clka);
    chk("bp_ready_before_pop", req_ready, 0);
    tick();
    @(negedge clka);
    chk("bp_ready_after_pop", req_ready, 1);
    repeat (6) tick();

    // Boundary addresses with intermittent back-pressure.
    issue(1'b1, 11'h7FF, $urandom);
    issue(1'b1, 11'h000, $urandom);
    for (int i = 0; i < 10; i++) begin
      rsp_ready = (i % 3) != 0;
      issue(1'b0, (i % 2) ? 11'h000 : 11'h7FF, 32'h0);
    end
    rsp_ready = 1'b1;
    repeat (6) tick();
    chk("wrap_drained", expq.size(), 0);

    // Push and pop landing in the same cycle at count 2.
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 11'(k + 1);
      tick();
    end
    req_valid = 1'b0;
    @(negedge clka);
    chk("pp_count_1", dut.u_fifo.count, 1);
    tick();
    rsp_ready = 1'b1;
    @(negedge clka);
    chk("pp_count_2", dut.u_fifo.count, 2);
    chk("pp_push_now", dut.s2, 1);
    tick();
    rsp_ready = 1'b0;
    @(negedge clka);
    chk("pp_count_kept", dut.u_fifo.count, 2);
    tick();
    rsp_ready = 1'b1;
    repeat (5) tick();

    // Reset with two reads in flight and one buffered.
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 11'(k + 4);
      tick();
    end
    req_valid = 1'b0;
    chk("pre_reset_valid", rsp_valid, 1);
    #1 rsta = 1'b1;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_idle", idle, 1);
    chk("rst_req_ready", req_ready, 0);
    expq.delete();
    tick();
    tick();
    rsta = 1'b0;
    rsp_ready = 1'b1;
    vcnt = 0;
    repeat (6) tick();
    chk("no_stale_rsp", vcnt, 0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      n = $urandom_range(0, 17);
      a = (n < 16) ? 11'(n) : ((n == 16) ? 11'h7FF : 11'h000);
      req_valid = 1'($urandom_range(0, 1));
      req_we    = ($urandom_range(0, 2) == 0);
      req_addr  = a;
      req_wdata = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while ((expq.size() != 0 || !idle) && n < 100) begin
      tick();
      n++;
    end
    chk("rand_drained", expq.size(), 0);
    chk("rand_idle", idle, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
